// File: rtl/mem_data_capture_if.sv
// mem_data_capture_if: request/ready capture bus between the memory controller and the MDR.
interface mem_data_capture_if #(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
);
  logic              req;
  logic [LANE_W-1:0] addr_lo;
  logic [1:0]        size;
  logic              sign_ext;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [DATA_W-1:0] mdr_data;
  logic              mdr_valid;
  logic              busy;
  logic              timeout_err;
  modport master (
    output req, addr_lo, size, sign_ext, mem_data, mem_ready,
    input  mdr_data, mdr_valid, busy, timeout_err
  );
  modport slave (
    input  req, addr_lo, size, sign_ext, mem_data, mem_ready,
    output mdr_data, mdr_valid, busy, timeout_err
  );
endinterface

// File: rtl/mem_data_capture.sv
// mem_data_capture: memory data register capturing variable-latency read data, with lane alignment, extension and a watchdog.
module mem_data_capture #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input logic clk,
  input logic reset,
  mem_data_capture_if.slave bus
);
  localparam int LANE_W = $clog2(DATA_W/8);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LANE_W-1:0] lo_q, lo_d, lo, off;
  logic [1:0]        sz_q, sz_d, sz;
  logic              sx_q, sx_d, sx;
  logic [DATA_W-1:0] mdr_data_q, mdr_data_d, shifted, mask, ext;
  logic              mdr_valid_q, mdr_valid_d, timeout_err_q, timeout_err_d;
  logic              capture, expire;
  int                se;
  // A zero-wait capture uses the live controls; a waited one uses the latched copy.
  always_comb begin
    lo = state_q == WAIT ? lo_q : bus.addr_lo;
    sz = state_q == WAIT ? sz_q : bus.size;
    sx = state_q == WAIT ? sx_q : bus.sign_ext;
    se = int'(sz) >= LANE_W ? LANE_W : int'(sz);
    off = lo & ~LANE_W'((1 << se) - 1);
    shifted = bus.mem_data >> {off, 3'b000};
    mask = {DATA_W{1'b1}} >> (DATA_W - (8 << se));
    // A full-width mask leaves ~mask empty, so sign_ext has no effect there.
    ext = (shifted & mask) | ((sx && |(shifted & (mask ^ (mask >> 1)))) ? ~mask : '0);
  end
  always_comb begin
    capture = bus.mem_ready && (state_q == WAIT || bus.req);
    expire = state_q == WAIT && !bus.mem_ready && TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT);
    state_d = (capture || expire) ? IDLE : (state_q == IDLE && bus.req) ? WAIT : state_q;
    cnt_d = state_q == IDLE ? (bus.req ? CNT_W'(1) : cnt_q) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    lo_d = (state_q == IDLE && bus.req) ? bus.addr_lo : lo_q;
    sz_d = (state_q == IDLE && bus.req) ? bus.size : sz_q;
    sx_d = (state_q == IDLE && bus.req) ? bus.sign_ext : sx_q;
    mdr_data_d = capture ? ext : mdr_data_q;
    mdr_valid_d = capture;
    timeout_err_d = expire;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      lo_q          <= '0;
      sz_q          <= '0;
      sx_q          <= 1'b0;
      mdr_data_q    <= '0;
      mdr_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
      sz_q          <= sz_d;
      sx_q          <= sx_d;
      mdr_data_q    <= mdr_data_d;
      mdr_valid_q   <= mdr_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  assign bus.mdr_data    = mdr_data_q;
  assign bus.mdr_valid   = mdr_valid_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = state_q == WAIT;
endmodule

// File: tb/tb_mem_data_capture.sv
// tb_mem_data_capture: randomized and directed checks of mem_data_capture (32-bit/TIMEOUT=4 and 64-bit builds) against a field-extraction model.
module tb_mem_data_capture;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] last32 = '0;
  always #5 clk = ~clk;
  mem_data_capture_if #(.DATA_W(32)) b32 ();
  mem_data_capture_if #(.DATA_W(64)) b64 ();
  mem_data_capture #(.DATA_W(32), .TIMEOUT(4), .CNT_W(3)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  mem_data_capture #(.DATA_W(64), .TIMEOUT(15), .CNT_W(4)) dut64 (.clk(clk), .reset(reset), .bus(b64));

  function automatic logic [63:0] model(input int dw, input logic [63:0] d, input int a, input int sz, input bit sx);
    int nb, off;
    logic [63:0] f, m;
    nb = (1 << sz) < dw / 8 ? (1 << sz) : dw / 8;
    off = (a / nb) * nb;
    if (nb == 8) return d;
    m = (64'd1 << (8 * nb)) - 64'd1;
    f = (d >> (8 * off)) & m;
    if (sx && nb < dw / 8 && ((f >> (8 * nb - 1)) & 64'd1) != 0) f = f | ~m;
    return dw == 32 ? (f & 64'hFFFF_FFFF) : f;
  endfunction

  // waits: 0 = zero-wait, k = ready on the k-th WAIT cycle, -1 = never ready.
  task automatic txn32(input int a, input int sz, input bit sx, input logic [31:0] dat, input int waits,
                       output int bcnt, output logic v, output logic [31:0] d, output logic e, output logic v2);
    b32.req = 1'b1; b32.addr_lo = 2'(a); b32.size = 2'(sz); b32.sign_ext = sx;
    b32.mem_data = dat; b32.mem_ready = (waits == 0);
    bcnt = 0;
    @(negedge clk);
    b32.req = 1'b0; b32.mem_ready = 1'b0; b32.mem_data = $urandom;
    b32.addr_lo = 2'($urandom); b32.size = 2'($urandom); b32.sign_ext = 1'($urandom);
    for (int k = 1; k <= 20 && b32.busy; k++) begin
      bcnt++;
      if (k == waits) begin b32.mem_ready = 1'b1; b32.mem_data = dat; end
      @(negedge clk);
      b32.mem_ready = 1'b0; b32.mem_data = $urandom;
    end
    v = b32.mdr_valid; d = b32.mdr_data; e = b32.timeout_err;
    @(negedge clk);
    v2 = b32.mdr_valid | b32.timeout_err;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (b32.mdr_data !== 32'h0 || b32.mdr_valid !== 1'b0) begin failures++; $display("FAIL reset_init data=%h valid=%b want 0/0", b32.mdr_data, b32.mdr_valid); end
    checks++; if (b32.busy !== 1'b0 || b32.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_init busy=%b err=%b want 0/0", b32.busy, b32.timeout_err); end
    @(negedge clk); reset = 1'b0;
    b32.req = 1'b1; b32.size = 2'd2; b32.addr_lo = 2'd0; b32.sign_ext = 1'b0; b32.mem_data = 32'h5A5A_1234; b32.mem_ready = 1'b1;
    @(negedge clk); b32.req = 1'b0; b32.mem_ready = 1'b0;
    checks++; if (b32.mdr_data !== 32'h5A5A_1234) begin failures++; $display("FAIL pre_reset_capture got %h want 5a5a1234", b32.mdr_data); end
    b32.req = 1'b1;
    @(negedge clk); b32.req = 1'b0;
    checks++; if (b32.busy !== 1'b1) begin failures++; $display("FAIL wait_entry busy=%b want 1", b32.busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (b32.busy !== 1'b0 || b32.mdr_data !== 32'h0) begin failures++; $display("FAIL reset_mid_wait busy=%b data=%h want 0/0", b32.busy, b32.mdr_data); end
    checks++; if (b32.mdr_valid !== 1'b0 || b32.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_mid_wait valid=%b err=%b want 0/0", b32.mdr_valid, b32.timeout_err); end
    @(negedge clk); reset = 1'b0;
    b32.req = 1'b1; b32.mem_ready = 1'b0;
    @(negedge clk); b32.req = 1'b0;
    checks++; if (b32.busy !== 1'b1) begin failures++; $display("FAIL busy_after_release busy=%b want 1", b32.busy); end
    b32.mem_ready = 1'b1; b32.mem_data = 32'h0BAD_F00D;
    @(negedge clk); b32.mem_ready = 1'b0;
    checks++; if (b32.mdr_data !== 32'h0BAD_F00D || b32.busy !== 1'b0) begin failures++; $display("FAIL post_reset_capture data=%h busy=%b want 0badf00d/0", b32.mdr_data, b32.busy); end
    last32 = 32'h0BAD_F00D;
    @(negedge clk);
  endtask

  task automatic test_zero_wait;
    int bc; logic v, e, v2; logic [31:0] d;
    txn32(0, 2, 1'b0, 32'hDEAD_BEEF, 0, bc, v, d, e, v2);
    checks++; if (v !== 1'b1 || d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL zero_wait valid=%b data=%h want 1/deadbeef", v, d); end
    checks++; if (bc !== 0 || v2 !== 1'b0) begin failures++; $display("FAIL zero_wait busy_cycles=%0d trailing_pulse=%b want 0/0", bc, v2); end
    last32 = 32'hDEAD_BEEF;
  endtask

  task automatic test_signed_byte;
    int bc; logic v, e, v2; logic [31:0] d;
    txn32(2, 0, 1'b1, 32'h12A4_5678, 3, bc, v, d, e, v2);
    checks++; if (bc !== 3 || v !== 1'b1) begin failures++; $display("FAIL sbyte busy_cycles=%0d valid=%b want 3/1", bc, v); end
    checks++; if (d !== 32'hFFFF_FFA4) begin failures++; $display("FAIL sbyte data=%h want ffffffa4", d); end
    txn32(2, 0, 1'b0, 32'h12A4_5678, 3, bc, v, d, e, v2);
    checks++; if (d !== 32'h0000_00A4 || v !== 1'b1 || v2 !== 1'b0) begin failures++; $display("FAIL ubyte data=%h valid=%b tail=%b want 000000a4/1/0", d, v, v2); end
    last32 = 32'h0000_00A4;
  endtask

  task automatic test_misaligned_half;
    int bc; logic v, e, v2; logic [31:0] d;
    txn32(3, 1, 1'b1, 32'h8001_0000, 2, bc, v, d, e, v2);
    checks++; if (d !== 32'hFFFF_8001 || v !== 1'b1) begin failures++; $display("FAIL mis_half data=%h valid=%b want ffff8001/1", d, v); end
    last32 = 32'hFFFF_8001;
  endtask

  task automatic test_timeout;
    int bc; logic v, e, v2; logic [31:0] d;
    txn32(0, 2, 1'b0, 32'h1111_2222, -1, bc, v, d, e, v2);
    checks++; if (bc !== 4 || e !== 1'b1 || v !== 1'b0) begin failures++; $display("FAIL timeout busy_cycles=%0d err=%b valid=%b want 4/1/0", bc, e, v); end
    checks++; if (d !== last32 || v2 !== 1'b0 || b32.busy !== 1'b0) begin failures++; $display("FAIL timeout_hold data=%h tail=%b busy=%b want %h/0/0", d, v2, b32.busy, last32); end
    txn32(0, 2, 1'b0, 32'h3333_4444, 4, bc, v, d, e, v2);
    checks++; if (bc !== 4 || e !== 1'b0 || v !== 1'b1 || d !== 32'h3333_4444) begin failures++; $display("FAIL ready_on_expiry cycles=%0d err=%b valid=%b data=%h want 4/0/1/33334444", bc, e, v, d); end
    last32 = 32'h3333_4444;
  endtask

  task automatic test_ignored_req;
    int pulses = 0;
    b32.req = 1'b1; b32.addr_lo = 2'd1; b32.size = 2'd1; b32.sign_ext = 1'b0; b32.mem_ready = 1'b0; b32.mem_data = 32'hCAFE_F00D;
    @(negedge clk); b32.req = 1'b1;
    @(negedge clk); b32.req = 1'b0;
    @(negedge clk); b32.req = 1'b1; b32.mem_ready = 1'b1;
    @(negedge clk); b32.req = 1'b0; b32.mem_ready = 1'b0;
    pulses += int'(b32.mdr_valid);
    checks++; if (b32.mdr_data !== 32'h0000_F00D || b32.busy !== 1'b0) begin failures++; $display("FAIL ignored_req data=%h busy=%b want 0000f00d/0", b32.mdr_data, b32.busy); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); pulses += int'(b32.mdr_valid) + int'(b32.busy); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL ignored_req valid_pulses_plus_busy=%0d want 1", pulses); end
    last32 = 32'h0000_F00D;
  endtask

  task automatic test_random;
    int a, sz, w, bc; bit sx; logic v, e, v2; logic [31:0] d, dat, exp_d; logic [63:0] m;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 3); sz = $urandom_range(0, 3); sx = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 5); dat = $urandom;
      m = model(32, {32'h0, dat}, a, sz, sx);
      exp_d = w <= 4 ? m[31:0] : last32;
      txn32(a, sz, sx, dat, w, bc, v, d, e, v2);
      checks++;
      if (d !== exp_d || v !== (w <= 4) || e !== (w > 4) || bc !== (w > 4 ? 4 : w) || v2 !== 1'b0)
        begin failures++; $display("FAIL rand%0d a=%0d sz=%0d sx=%0d w=%0d data=%h v=%b e=%b cyc=%0d want %h", n, a, sz, sx, w, d, v, e, bc, exp_d); end
      last32 = exp_d;
    end
  endtask

  task automatic test_wide64;
    int a, sz; bit sx; logic [63:0] dat, exp_d;
    for (int n = 0; n < 12; n++) begin
      if (n == 0) begin a = 5; sz = 3; sx = 1'b1; dat = 64'hF123_4567_89AB_CDEF; end
      else if (n == 1) begin a = 5; sz = 2; sx = 1'b1; dat = 64'hF123_4567_89AB_CDEF; end
      else begin a = $urandom_range(0, 7); sz = $urandom_range(0, 3); sx = 1'($urandom_range(0, 1)); dat = {$urandom, $urandom}; end
      exp_d = n == 0 ? 64'hF123_4567_89AB_CDEF : n == 1 ? 64'hFFFF_FFFF_F123_4567 : model(64, dat, a, sz, sx);
      b64.req = 1'b1; b64.addr_lo = 3'(a); b64.size = 2'(sz); b64.sign_ext = sx; b64.mem_data = dat; b64.mem_ready = 1'b1;
      @(negedge clk); b64.req = 1'b0; b64.mem_ready = 1'b0;
      checks++;
      if (b64.mdr_data !== exp_d || b64.mdr_valid !== 1'b1 || b64.busy !== 1'b0 || b64.timeout_err !== 1'b0)
        begin failures++; $display("FAIL w64_%0d a=%0d sz=%0d sx=%0d data=%h valid=%b want %h", n, a, sz, sx, b64.mdr_data, b64.mdr_valid, exp_d); end
    end
  endtask

  initial begin
    b32.req = 1'b0; b32.addr_lo = '0; b32.size = '0; b32.sign_ext = 1'b0; b32.mem_data = '0; b32.mem_ready = 1'b0;
    b64.req = 1'b0; b64.addr_lo = '0; b64.size = '0; b64.sign_ext = 1'b0; b64.mem_data = '0; b64.mem_ready = 1'b0;
    test_reset;
    test_zero_wait;
    test_signed_byte;
    test_misaligned_half;
    test_timeout;
    test_ignored_req;
    test_random;
    test_wide64;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_data_capture.md
Name: mem_data_capture

Overview:
Parametrised memory data register for the multicycle datapath. It captures read data from a variable-latency memory under a request/ready handshake. It extracts and aligns the byte, halfword or full-width field selected by the address low bits, zero- or sign-extends it, and holds the result for the writeback stage. A watchdog counter flags memories that never answer.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, at least 16 (32 and 64 supported)
TIMEOUT, 15, max WAIT cycles before abort; 0 disables watchdog
CNT_W, 4, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  start a capture (sampled only in IDLE)
addr_lo  in  LANE_W  byte offset in word; LANE_W = clog2(DATA_W/8)
size  in  2  access size: 2^size bytes (0 byte, 1 half, 2 word, 3 dword); >= DATA_W/8 means full width
sign_ext  in  1  1 = sign-extend field, 0 = zero-extend
mem_data  in  DATA_W  raw read data from memory
mem_ready  in  1  memory data valid this cycle
mdr_data  out  DATA_W  registered, aligned, extended data
mdr_valid  out  1  one-cycle pulse: mdr_data updated
busy  out  1  capture in progress (state WAIT)
timeout_err  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Reset is asynchronous. State = IDLE; mdr_data, mdr_valid, busy and timeout_err = 0; counter = 0; latched controls = 0.
- States: IDLE and WAIT.
- IDLE, req=0: hold. mdr_data retains its last value indefinitely.
- IDLE, req=1, mem_ready=0: latch addr_lo, size and sign_ext. Go to WAIT. Counter <= 1. busy=1 from the next cycle.
- IDLE, req=1, mem_ready=1 (zero-wait): capture at this edge using the live addr_lo/size/sign_ext. mdr_valid=1 next cycle. Stay IDLE.
- WAIT, mem_ready=1: capture using the latched controls. mdr_valid=1 next cycle. Go to IDLE; busy=0.
- WAIT, mem_ready=0, TIMEOUT!=0 and counter==TIMEOUT: go to IDLE. timeout_err=1 for one cycle. mdr_data unchanged, mdr_valid=0.
- WAIT otherwise: counter increments, saturating at its maximum.
- If mem_ready=1 on the expiry cycle, ready wins: normal capture, no error.
- req while in WAIT is ignored and not queued. mem_ready while in IDLE with req=0 is ignored.
- Extraction:
  - nbytes = min(2^size, DATA_W/8).
  - offset = addr_lo with its low log2(nbytes) bits forced to 0 (misaligned accesses round down, no fault).
  - field = mem_data[8*offset +: 8*nbytes].
  - Result = field zero-extended, or sign-extended from the field MSB, to DATA_W.
  - A full-width access ignores sign_ext.
- Latency: mdr_data and mdr_valid update on the edge where mem_ready is seen, so they are visible the next cycle. Minimum 1 cycle after req.
- Reset asserted mid-WAIT aborts immediately: no mdr_valid, no timeout_err, mdr_data=0.
- mdr_valid and timeout_err are never both 1.

Test Plan:
- Reset: assert reset mid-WAIT -> all outputs 0 immediately and state IDLE. After release, req with mem_ready=0 -> busy=1 next cycle.
- Zero-wait word (DATA_W=32): req=1, size=2, mem_ready=1, mem_data=32'hDEADBEEF -> next cycle mdr_data=32'hDEADBEEF, mdr_valid=1 for exactly one cycle, busy stays 0.
- Signed byte, 3 wait cycles: req with addr_lo=2, size=0, sign_ext=1, mem_data=32'h12A45678 -> busy=1 for 3 cycles, then mdr_data=32'hFFFFFFA4 and mdr_valid=1. Repeat with sign_ext=0 -> 32'h000000A4.
- Misaligned half: addr_lo=3, size=1, sign_ext=1, mem_data=32'h80010000 -> offset rounds to 2, mdr_data=32'hFFFF8001.
- Timeout: TIMEOUT=4, req, mem_ready held low -> timeout_err pulses one cycle after the 4th WAIT cycle, mdr_data keeps its previous value, busy=0. Repeat with mem_ready=1 on the 4th WAIT cycle -> capture, no error.
- Ignored inputs: req pulsed during WAIT and again on the completion cycle -> exactly one mdr_valid, then IDLE with busy=0. DATA_W=64 build: size=3, addr_lo=5 -> full 64-bit word.
